// File: rtl/key_cond_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package key_cond_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_WAIT_REL,
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_LONG,
        S_REL_DB
    } key_state_e;

    // Bits needed for a saturating counter that must be able to hold max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button inputs and conditioned command outputs of the key conditioner.
interface key_conditioner_if #(
    parameter int unsigned N_KEYS = 3
);
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] long_press;
    logic [N_KEYS-1:0] level;

    modport master (output key_n, input press, long_press, level);
    modport slave  (input key_n, output press, long_press, level);
endinterface

// File: rtl/key_debounce_fsm.sv
// One key: 2-FF synchroniser, press/release debounce, hold timer and long-press detection.
module key_debounce_fsm
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 30720,
    parameter int unsigned LONG_CYCLES     = 3072000
) (
    input  logic i_AUD_BCLK,
    input  logic i_rst_n,
    input  logic key_n,
    output logic req,
    output logic long_pulse,
    output logic level
);
    localparam int unsigned DBW = cnt_w(DEBOUNCE_CYCLES);
    localparam int unsigned HW  = cnt_w(LONG_CYCLES);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(LONG_CYCLES);

    logic [1:0]    sync_q;
    logic          p;
    key_state_e    state_q, state_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_fired_q, long_fired_d;
    logic          req_d, long_d, level_d;

    // Synchroniser resets to "released" so reset never looks like a press.
    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= 2'b11;
        else          sync_q <= {sync_q[0], key_n};
    end

    assign p = ~sync_q[1];

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_WAIT_REL;
            db_cnt_q     <= '0;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            req          <= 1'b0;
            long_pulse   <= 1'b0;
            level        <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            req          <= req_d;
            long_pulse   <= long_d;
            level        <= level_d;
        end
    end

    // Next state; counters only advance below their limit, so they saturate.
    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        req_d        = 1'b0;
        long_d       = 1'b0;
        unique case (state_q)
            S_WAIT_REL: begin
                if (p) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end
            S_IDLE: begin
                if (p) begin
                    state_d  = S_PRESS_DB;
                    db_cnt_d = DBW'(1);
                end
            end
            S_PRESS_DB: begin
                if (!p) begin
                    state_d  = S_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = S_HELD;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    req_d      = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end
            S_HELD: begin
                if (!p) begin
                    state_d  = S_REL_DB;
                    db_cnt_d = DBW'(1);
                end else if (hold_cnt_q == HOLD_MAX) begin
                    state_d      = S_LONG;
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_LONG: begin
                if (!p) begin
                    state_d  = S_REL_DB;
                    db_cnt_d = DBW'(1);
                end
            end
            S_REL_DB: begin
                // A glitch back to pressed resumes the hold timer where it froze.
                if (p) begin
                    db_cnt_d = '0;
                    if (long_fired_q) begin
                        state_d = S_LONG;
                    end else if (hold_cnt_q == HOLD_MAX) begin
                        state_d      = S_LONG;
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                    end else begin
                        state_d    = S_HELD;
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end else if (db_cnt_q == DB_LAST) begin
                    state_d      = S_IDLE;
                    db_cnt_d     = '0;
                    long_fired_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + DBW'(1);
                end
            end
            default: state_d = S_WAIT_REL;
        endcase
        level_d = (state_d == S_HELD) || (state_d == S_LONG) || (state_d == S_REL_DB);
    end

endmodule

// File: rtl/key_conditioner.sv
// Per-key conditioning plus a fixed-priority arbiter that serialises press pulses.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 30720,
    parameter int unsigned LONG_CYCLES     = 3072000
) (
    input  logic              i_AUD_BCLK,
    input  logic              i_rst_n,
    key_conditioner_if.slave  bus
);
    logic [N_KEYS-1:0] req;
    logic [N_KEYS-1:0] long_vec;
    logic [N_KEYS-1:0] level_vec;
    logic [N_KEYS-1:0] pend_q;
    logic [N_KEYS-1:0] press_q;
    logic [N_KEYS-1:0] cand_c;
    logic [N_KEYS-1:0] grant_c;

    for (genvar k = 0; k < int'(N_KEYS); k++) begin : g_key
        key_debounce_fsm #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_key (
            .i_AUD_BCLK (i_AUD_BCLK),
            .i_rst_n    (i_rst_n),
            .key_n      (bus.key_n[k]),
            .req        (req[k]),
            .long_pulse (long_vec[k]),
            .level      (level_vec[k])
        );
    end

    // Lowest set bit of pending-or-new requests wins this cycle.
    always_comb begin
        cand_c  = pend_q | req;
        grant_c = cand_c & (~cand_c + N_KEYS'(1));
    end

    always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q  <= '0;
            press_q <= '0;
        end else begin
            pend_q  <= cand_c & ~grant_c;
            press_q <= grant_c;
        end
    end

    assign bus.press      = press_q;
    assign bus.long_press = long_vec;
    assign bus.level      = level_vec;

endmodule
